// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing one async-FIFO write port among NREQ requesters.
// Each grant admits up to BURST words, then one IDLE cycle re-arbitrates.
module fifo_write_arbiter #(
    parameter int DSIZE = 8,
    parameter int NREQ  = 4,
    parameter int BURST = 4
) (
    input  logic                  wclk,
    input  logic                  wrst,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*DSIZE-1:0] req_data,
    output logic [NREQ-1:0]       req_ready,
    input  logic                  wfull,
    output logic                  winc,
    output logic [DSIZE-1:0]      wdata,
    output logic [NREQ-1:0]       grant,
    output logic [15:0]           words_written
);
    localparam int IW = $clog2(NREQ);

    typedef enum logic {IDLE, BURST_ST} state_t;

    state_t          state_q;
    logic [IW-1:0]   owner_q;
    logic [IW-1:0]   rr_ptr_q;
    logic [4:0]      beat_cnt_q;
    logic [NREQ-1:0] grant_q;
    logic [15:0]     words_written_q;

    logic [IW-1:0]   owner_d;
    logic [NREQ-1:0] owner_oh;
    logic [NREQ-1:0] owner_d_oh;
    logic            owner_valid;
    logic            last_beat;
    logic [DSIZE-1:0] data_arr [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : g_data
        assign data_arr[g] = req_data[g*DSIZE +: DSIZE];
    end

    // Scan downward so the lowest offset from rr_ptr wins.
    always_comb begin
        logic [IW-1:0] cand;
        cand    = rr_ptr_q;
        owner_d = rr_ptr_q;
        for (int k = NREQ-1; k >= 0; k--) begin
            cand = rr_ptr_q + IW'(k);
            if (req_valid[cand]) owner_d = cand;
        end
    end

    assign owner_oh    = {{(NREQ-1){1'b0}}, 1'b1} << owner_q;
    assign owner_d_oh  = {{(NREQ-1){1'b0}}, 1'b1} << owner_d;
    assign owner_valid = req_valid[owner_q];
    assign req_ready   = (state_q == BURST_ST && !wfull && !wrst) ? owner_oh : '0;
    assign winc        = owner_valid && req_ready[owner_q];
    assign wdata       = (state_q == BURST_ST) ? data_arr[owner_q] : '0;
    assign last_beat   = (beat_cnt_q == 5'(BURST-1));
    assign grant         = grant_q;
    assign words_written = words_written_q;

    always_ff @(posedge wclk) begin
        if (wrst) begin
            state_q         <= IDLE;
            owner_q         <= '0;
            rr_ptr_q        <= '0;
            beat_cnt_q      <= '0;
            grant_q         <= '0;
            words_written_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (|req_valid) begin
                        state_q    <= BURST_ST;
                        owner_q    <= owner_d;
                        beat_cnt_q <= '0;
                        grant_q    <= owner_d_oh;
                    end
                end
                BURST_ST: begin
                    if (winc) begin
                        beat_cnt_q      <= beat_cnt_q + 5'd1;
                        words_written_q <= words_written_q + 16'd1;
                    end
                    // A dropped valid releases the port even mid-burst.
                    if (!owner_valid || (winc && last_beat)) begin
                        state_q  <= IDLE;
                        grant_q  <= '0;
                        rr_ptr_q <= owner_q + IW'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed bench for fifo_write_arbiter: transaction-level model checked every
// cycle, plus literal expectations on the logged write stream.
module tb_fifo_write_arbiter;
    localparam int NREQ  = 4;
    localparam int DSIZE = 8;
    localparam int BURST = 4;
    localparam logic [31:0] NONE = 32'hFFFF_FFFF;

    logic        wclk = 1'b0;
    logic        wrst = 1'b1;
    logic [3:0]  req_valid = '0;
    logic [31:0] req_data = '0;
    logic [3:0]  req_ready;
    logic        wfull = 1'b0;
    logic        winc;
    logic [7:0]  wdata;
    logic [3:0]  grant;
    logic [15:0] words_written;

    always #5 wclk = ~wclk;

    fifo_write_arbiter #(.DSIZE(DSIZE), .NREQ(NREQ), .BURST(BURST)) dut (
        .wclk(wclk), .wrst(wrst), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .wfull(wfull), .winc(winc), .wdata(wdata),
        .grant(grant), .words_written(words_written)
    );

    int  tests = 0;
    int  fails = 0;
    int  cyc   = 0;
    int  base  = 0;
    bit  chk_en = 1'b0;

    logic [7:0] src [NREQ][$];
    logic [3:0] en = '0;

    typedef struct { int c; int who; logic [7:0] d; } wr_t;
    wr_t wlog[$];

    // Model: owner -1 means no burst in progress; left counts remaining beats.
    int mowner = -1;
    int mleft  = 0;
    int mrr    = 0;
    int mcount = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] w(input int who, input logic [7:0] d);
        return {16'h0, 8'(who), d};
    endfunction

    task automatic chk_wr(input string name, input int c, input logic [31:0] exp);
        logic [31:0] act;
        act = NONE;
        foreach (wlog[j]) if (wlog[j].c == c) act = w(wlog[j].who, wlog[j].d);
        chk(name, act, exp);
    endtask

    task automatic drive();
        for (int i = 0; i < NREQ; i++) begin
            req_valid[i] = en[i] && (src[i].size() > 0);
            req_data[i*8 +: 8] = (src[i].size() > 0) ? src[i][0] : 8'h00;
        end
    endtask

    task automatic step();
        logic [3:0] hs;
        @(negedge wclk);
        hs = req_valid & req_ready;
        @(posedge wclk);
        #1;
        for (int i = 0; i < NREQ; i++) if (hs[i]) void'(src[i].pop_front());
        drive();
    endtask

    task automatic do_reset();
        wrst = 1'b1;
        en = '0;
        for (int i = 0; i < NREQ; i++) src[i].delete();
        drive();
        step();
        wrst = 1'b0;
    endtask

    always @(negedge wclk) begin
        logic [3:0] er;
        logic       ew;
        int         nx;
        int         who;
        cyc++;
        er = '0;
        if (mowner >= 0 && !wfull && !wrst) er = 4'(1 << mowner);
        ew = (er != 0) && req_valid[mowner];
        if (chk_en) begin
            chk("req_ready", 32'(req_ready), 32'(er));
            chk("winc", 32'(winc), 32'(ew));
            chk("grant", 32'(grant), (mowner >= 0) ? 32'(1 << mowner) : 32'h0);
            chk("words_written", 32'(words_written), 32'(mcount));
            if (ew) chk("wdata", 32'(wdata), 32'(req_data[mowner*8 +: 8]));
            else if (mowner < 0) chk("wdata_idle", 32'(wdata), 32'h0);
        end
        if (winc) begin
            who = -1;
            for (int i = 0; i < NREQ; i++) if (grant[i]) who = i;
            wlog.push_back('{c: cyc, who: who, d: wdata});
        end
        if (wrst) begin
            mowner = -1; mrr = 0; mcount = 0;
        end else if (mowner < 0) begin
            nx = -1;
            for (int k = NREQ-1; k >= 0; k--) if (req_valid[(mrr+k) % NREQ]) nx = (mrr+k) % NREQ;
            if (nx >= 0) begin mowner = nx; mleft = BURST; end
        end else if (!req_valid[mowner]) begin
            mrr = (mowner + 1) % NREQ; mowner = -1;
        end else if (ew) begin
            mcount = (mcount + 1) % 65536;
            mleft--;
            if (mleft == 0) begin mrr = (mowner + 1) % NREQ; mowner = -1; end
        end
    end

    initial begin
        // Reset held with every requester asking.
        en = 4'b1111;
        for (int i = 0; i < NREQ; i++) src[i].push_back(8'(8'h10 + i));
        drive();
        @(posedge wclk);
        #1;
        chk_en = 1'b1;
        for (int k = 0; k < 2; k++) begin
            chk("rst_winc", 32'(winc), 32'h0);
            chk("rst_ready", 32'(req_ready), 32'h0);
            chk("rst_grant", 32'(grant), 32'h0);
            chk("rst_words", 32'(words_written), 32'h0);
            step();
        end

        // Single requester 1, eight words.
        wrst = 1'b0;
        for (int i = 0; i < NREQ; i++) src[i].delete();
        for (int k = 0; k < 8; k++) src[1].push_back(8'(8'hA0 + k));
        en = 4'b0010;
        drive();
        base = cyc;
        repeat (10) step();
        for (int k = 0; k < 8; k++)
            chk_wr("single_wr", base + ((k < 4) ? 2 + k : 3 + k), w(1, 8'(8'hA0 + k)));
        chk_wr("single_idle1", base + 1, NONE);
        chk_wr("single_idle6", base + 6, NONE);
        chk("single_words", 32'(words_written), 32'd8);

        // Round-robin with all four requesting.
        do_reset();
        for (int i = 0; i < NREQ; i++)
            for (int k = 0; k < 8; k++) src[i].push_back(8'(i*16 + k));
        en = 4'b1111;
        drive();
        base = cyc;
        repeat (20) step();
        chk("rr_words20", 32'(words_written), 32'd16);
        repeat (2) step();
        for (int b = 0; b < 4; b++)
            for (int k = 0; k < 4; k++)
                chk_wr("rr_wr", base + 2 + 5*b + k, w(b, 8'(b*16 + k)));
        chk_wr("rr_wrap0", base + 22, w(0, 8'h04));

        // Backpressure on owner 0 at beat 2 for three cycles.
        do_reset();
        for (int k = 0; k < 4; k++) src[0].push_back(8'(8'hC0 + k));
        en = 4'b0001;
        drive();
        base = cyc;
        for (int k = 1; k <= 9; k++) begin
            wfull = (k >= 4 && k <= 6);
            if (k == 5) chk("bp_grant_stall", 32'(grant), 32'h1);
            step();
        end
        wfull = 1'b0;
        chk_wr("bp_b0", base + 2, w(0, 8'hC0));
        chk_wr("bp_b1", base + 3, w(0, 8'hC1));
        for (int k = 4; k <= 6; k++) chk_wr("bp_stall", base + k, NONE);
        chk_wr("bp_b2", base + 7, w(0, 8'hC2));
        chk_wr("bp_b3", base + 8, w(0, 8'hC3));
        chk("bp_words", 32'(words_written), 32'd4);

        // Owner 2 runs dry after two beats while requester 3 waits.
        do_reset();
        src[2].push_back(8'hD0);
        src[2].push_back(8'hD1);
        for (int k = 0; k < 4; k++) src[3].push_back(8'(8'hE0 + k));
        en = 4'b1100;
        drive();
        base = cyc;
        for (int k = 1; k <= 10; k++) begin
            if (k == 5) begin
                chk("er_idle_grant", 32'(grant), 32'h0);
                chk("er_words2", 32'(words_written), 32'd2);
            end
            if (k == 6) chk("er_grant3", 32'(grant), 32'h8);
            step();
        end
        chk_wr("er_d0", base + 2, w(2, 8'hD0));
        chk_wr("er_d1", base + 3, w(2, 8'hD1));
        chk_wr("er_nowr", base + 4, NONE);
        chk_wr("er_e0", base + 6, w(3, 8'hE0));

        // Reset lands on beat 1 of owner 1; requester 0 appears at the same time.
        do_reset();
        for (int k = 0; k < 4; k++) src[1].push_back(8'(8'hF0 + k));
        src[0].push_back(8'hB0);
        en = 4'b0010;
        drive();
        base = cyc;
        for (int k = 1; k <= 7; k++) begin
            if (k == 3) begin
                wrst = 1'b1;
                en = 4'b0011;
                drive();
                #1;
                chk("rm_winc", 32'(winc), 32'h0);
                chk("rm_ready", 32'(req_ready), 32'h0);
            end
            if (k == 4) begin
                wrst = 1'b0;
                chk("rm_grant_idle", 32'(grant), 32'h0);
                chk("rm_words0", 32'(words_written), 32'h0);
            end
            if (k == 5) chk("rm_grant0", 32'(grant), 32'h1);
            step();
        end
        chk_wr("rm_f0", base + 2, w(1, 8'hF0));
        chk_wr("rm_cut", base + 3, NONE);
        chk_wr("rm_b0", base + 5, w(0, 8'hB0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/fifo_write_arbiter.md
FIFO_WRITE_ARBITER -- requirements
Module: fifo_write_arbiter

Interface
REQ-001 Parameter DSIZE, default 8: width of one data word, equal to the async FIFO write data width.
REQ-002 Parameter NREQ, default 4: number of requesters sharing the FIFO write port (power of 2, 2..8).
REQ-003 Parameter BURST, default 4: maximum words accepted per grant (1..16).
REQ-004 wclk  in  1  write-domain clock; the block uses only this clock.
REQ-005 wrst  in  1  reset, synchronous to wclk, active-high.
REQ-006 req_valid  in  NREQ  per-requester word-available flag.
REQ-007 req_data  in  NREQ*DSIZE  per-requester word; requester i occupies bits [i*DSIZE +: DSIZE].
REQ-008 req_ready  out  NREQ  per-requester accept strobe; transfer i occurs when req_valid[i] and req_ready[i] are both high at a wclk edge.
REQ-009 wfull  in  1  FIFO full flag from the write domain.
REQ-010 winc  out  1  FIFO write enable.
REQ-011 wdata  out  DSIZE  FIFO write data.
REQ-012 grant  out  NREQ  registered one-hot owner indication; all zeros when no burst is active.
REQ-013 words_written  out  16  count of FIFO writes issued since reset; wraps 0xFFFF->0x0000.

Function
REQ-014 FSM states SHALL be IDLE and BURST only.
REQ-015 IDLE: if any req_valid bit is high, the next state SHALL be BURST, with owner = first valid index searched upward from rr_ptr modulo NREQ, and beat_cnt = 0.
REQ-016 IDLE with no req_valid: the state SHALL remain IDLE and all registers SHALL hold.
REQ-017 req_ready[i] SHALL be combinational and equal to (state==BURST && owner==i && !wfull && !wrst); all other bits SHALL be 0.
REQ-018 winc SHALL equal req_valid[owner] && req_ready[owner]; wdata SHALL equal req_data of the owner (don't-care when winc=0, and driven to 0 in IDLE).
REQ-019 Each winc SHALL increment beat_cnt and words_written by 1 at that edge.
REQ-020 BURST to IDLE SHALL occur on a transfer with beat_cnt==BURST-1, or on any cycle where req_valid[owner]==0; in either case rr_ptr SHALL become (owner+1) mod NREQ.
REQ-021 wfull high in BURST with req_valid[owner] high: winc=0, beat_cnt held, state held; there is no stall timeout.
REQ-022 Every burst SHALL be followed by exactly one IDLE cycle before the next grant (the arbitration cycle).
REQ-023 grant SHALL be one-hot of owner in BURST and 0 in IDLE, registered, so it matches state on the same cycle.
REQ-024 At most one winc SHALL occur per wclk cycle; winc SHALL never be high while wfull is high.

Reset
REQ-025 While wrst is high at a wclk edge: state=IDLE, rr_ptr=0, owner=0, beat_cnt=0, grant=0, words_written=0.
REQ-026 While wrst is high, winc and req_ready SHALL be forced to 0 combinationally, including reset asserted mid-burst.
REQ-027 After wrst deasserts, the first grant SHALL follow arbitration from rr_ptr=0.

Verification
REQ-028 Reset: wrst=1 for 2 cycles with req_valid=4'b1111, wfull=0 -> winc=0 and req_ready=0 on every cycle, grant=0, words_written=0.
REQ-029 Single requester: after reset, req_valid=4'b0010 held with data 0xA0..0xA7, wfull=0 -> cycle 1 IDLE, cycles 2-5 grant=4'b0010 with winc=1 writing 0xA0..0xA3, cycle 6 IDLE, cycles 7-10 write 0xA4..0xA7.
REQ-030 Round-robin: req_valid=4'b1111 continuously -> grant order 0,1,2,3,0; each burst 4 beats; words_written=16 after 20 cycles.
REQ-031 Backpressure: owner 0, wfull=1 for 3 cycles starting at beat 2 -> winc=0 and beat_cnt held at 2 for those 3 cycles, burst completes with 4 writes total, no data lost or duplicated.
REQ-032 Early release: owner 2 drops req_valid after 2 beats while req_valid[3]=1 -> IDLE for one cycle, then grant=4'b1000, words_written advanced by exactly 2 for owner 2.
REQ-033 Reset mid-burst: wrst=1 at beat 1 of owner 1 -> winc=0 that cycle, next cycle IDLE with grant=0, words_written=0, next grant to the lowest valid index at or above 0.
